// File: rtl/mem_port_arbiter_if.sv
// Memory-port arbitration bus: per-requester request levels, shared ack, and
// registered ownership outputs.
interface mem_port_arbiter_if #(
    parameter int N = 8
);
    logic [N-1:0]         req;
    logic                 mem_ack;
    logic [N-1:0]         grant;
    logic [$clog2(N)-1:0] grant_idx;
    logic                 grant_valid;
    logic                 timeout;

    modport master (output req, mem_ack, input grant, grant_idx, grant_valid, timeout);
    modport slave  (input req, mem_ack, output grant, grant_idx, grant_valid, timeout);
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for one memory port: a single owner at a time, with
// release on ack, on request drop, or after TIMEOUT busy cycles.
module mem_port_arbiter #(
    parameter int N       = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          valid_q, valid_d;
    logic          timeout_q, timeout_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          found;
    logic [IW-1:0] pick;
    logic [IW-1:0] rr_next;
    logic          owner_req;

    // Descending scan so that the smallest offset from rr_q is the last to be written.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.req[(int'(rr_q) + i) % N]) begin
                found = 1'b1;
                pick  = IW'((int'(rr_q) + i) % N);
            end
        end
    end

    assign rr_next   = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
    assign owner_req = bus.req[idx_q];

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                valid_d = 1'b0;
                if (found) begin
                    state_d       = BUSY;
                    grant_d[pick] = 1'b1;
                    idx_d         = pick;
                    valid_d       = 1'b1;
                    cnt_d         = '0;
                end
            end
            BUSY: begin
                // Ack beats both abort and timeout; only a genuine stall pulses timeout.
                if (bus.mem_ack || !owner_req || cnt_q == LAST) begin
                    state_d   = RELEASE;
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    rr_d      = rr_next;
                    timeout_d = !bus.mem_ack && owner_req;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            rr_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: an owner/round-robin model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_mem_port_arbiter;
    localparam int N  = 8;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.N(N)) bus ();
    mem_port_arbiter #(.N(N), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int checks = 0;
    int passes = 0;
    bit armed  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: who owns the bus, how long it has waited, whether a gap is pending.
    int m_owner = -1;
    int m_last  = 0;
    int m_rr    = 0;
    int m_wait  = 0;
    bit m_gap   = 1'b0;
    bit m_to    = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1; m_last = 0; m_rr = 0; m_wait = 0; m_gap = 1'b0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner >= 0) begin
                if (bus.mem_ack || !bus.req[m_owner] || m_wait == TO - 1) begin
                    m_to    = !bus.mem_ack && bus.req[m_owner];
                    m_rr    = (m_owner + 1) % N;
                    m_owner = -1;
                    m_gap   = 1'b1;
                end else begin
                    m_wait++;
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (bus.req != '0) begin
                for (int k = N - 1; k >= 0; k--)
                    if (bus.req[(m_rr + k) % N]) m_owner = (m_rr + k) % N;
                m_last = m_owner;
                m_wait = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] eg;
        if (armed) begin
            eg = '0;
            if (m_owner >= 0) eg[m_owner] = 1'b1;
            chk("model_grant", bus.grant, eg);
            chk("model_idx", bus.grant_idx, m_last);
            chk("model_valid", bus.grant_valid, m_owner >= 0);
            chk("model_timeout", bus.timeout, m_to);
            chk("onehot_valid", $onehot0(bus.grant) && (bus.grant_valid == |bus.grant), 1);
        end
    end

    a_onehot: assert property (@(posedge clk) $onehot0(bus.grant) && (bus.grant_valid == |bus.grant))
        else $display("FAIL a_onehot: grant=%0h valid=%0b", bus.grant, bus.grant_valid);

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.grant_valid && n < 20);
        if (!bus.grant_valid) chk("wait_grant_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int held;
        rst = 1'b1; bus.req = '0; bus.mem_ack = 1'b0;
        tick();
        armed = 1'b1;
        tick();
        chk("rst_grant", bus.grant, 0);
        chk("rst_idx", bus.grant_idx, 0);
        chk("rst_valid", bus.grant_valid, 0);
        chk("rst_timeout", bus.timeout, 0);
        rst = 1'b0;

        // Latency and gap, then abort by dropping the request
        bus.req = 8'h10;
        tick(); chk("lat_c1", bus.grant, 8'h10);
        tick();
        tick(); bus.mem_ack = 1'b1;
        tick(); bus.mem_ack = 1'b0; chk("lat_c4", bus.grant, 0);
        tick(); chk("lat_c5", bus.grant, 0);
        tick(); chk("lat_c6", bus.grant, 8'h10);
        bus.req = '0;
        tick(); chk("abort_grant", bus.grant, 0); chk("abort_to", bus.timeout, 0);
        tick(); tick();

        // Round robin over all requesters
        do_reset();
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            wait_grant(n);
            if (k > 0) chk("rr_gap", n, 2);
            chk("rr_idx", bus.grant_idx, k % N);
            tick(); tick(); bus.mem_ack = 1'b1;
            tick(); bus.mem_ack = 1'b0;
        end
        bus.req = '0;
        tick(); tick();

        // Timeout
        do_reset();
        bus.req = 8'h04;
        wait_grant(n);
        held = 0;
        while (bus.grant_valid && held < 40) begin
            held++;
            tick();
        end
        chk("to_held", held, 15);
        chk("to_pulse", bus.timeout, 1);
        bus.req = 8'h0C;
        tick(); chk("to_pulse_end", bus.timeout, 0);
        wait_grant(n);
        chk("to_next_idx", bus.grant_idx, 3);
        bus.req = '0;
        tick(); tick(); tick();

        // Ack coinciding with the last busy cycle
        do_reset();
        bus.req = 8'h01;
        wait_grant(n);
        repeat (14) tick();
        bus.mem_ack = 1'b1;
        tick(); chk("coin_grant", bus.grant, 0); chk("coin_to", bus.timeout, 0);
        bus.mem_ack = 1'b0; bus.req = '0;
        tick(); tick();

        // Wrap from 7 to 0, then reset mid-busy
        do_reset();
        bus.req = 8'h80;
        wait_grant(n);
        chk("wrap_idx7", bus.grant_idx, 7);
        tick(); bus.mem_ack = 1'b1;
        tick(); bus.mem_ack = 1'b0; bus.req = 8'h81;
        wait_grant(n);
        chk("wrap_idx0", bus.grant_idx, 0);
        tick(); rst = 1'b1; bus.mem_ack = 1'b1;
        tick();
        chk("mid_rst_grant", bus.grant, 0);
        chk("mid_rst_idx", bus.grant_idx, 0);
        chk("mid_rst_valid", bus.grant_valid, 0);
        chk("mid_rst_to", bus.timeout, 0);
        tick(); rst = 1'b0; bus.mem_ack = 1'b0; bus.req = 8'h80;
        wait_grant(n);
        chk("post_rst_idx", bus.grant_idx, 7);
        chk("post_rst_grant", bus.grant, 8'h80);
        bus.req = '0;
        tick(); tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passes, checks);
        $fatal(1);
    end
endmodule
